// File: rtl/gb_mbc_mapper_if.sv
// Cartridge-side bus of the Game Boy bank mapper: raw Game Boy strobes/address/data in,
// memory chip address lines, selects and RTC read data out.
interface gb_mbc_mapper_if #(
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4
);
  logic [3:0]            GB_A;
  logic [7:0]            GB_D;
  logic                  GB_WR;
  logic                  GB_RD;
  logic                  RTC_TICK;
  logic [ROM_BANK_W-1:0] ROM_A;
  logic [RAM_BANK_W-1:0] RAM_A;
  logic                  ROM_CS;
  logic                  RAM_CS;
  logic                  DDIR;
  logic                  RTC_OE;
  logic [7:0]            RTC_DOUT;

  modport master (
    output GB_A, GB_D, GB_WR, GB_RD, RTC_TICK,
    input  ROM_A, RAM_A, ROM_CS, RAM_CS, DDIR, RTC_OE, RTC_DOUT
  );

  modport slave (
    input  GB_A, GB_D, GB_WR, GB_RD, RTC_TICK,
    output ROM_A, RAM_A, ROM_CS, RAM_CS, DDIR, RTC_OE, RTC_DOUT
  );
endinterface

// File: rtl/gb_mbc_mapper.sv
// Clocked MBC1/MBC3/MBC5 bank controller: bus writes are synchronised and committed on WR rising,
// registers update 3 CLK after GB_WR rises; chip selects and DDIR are combinational from the raw bus.
module gb_mbc_mapper #(
  parameter int MODE       = 5,
  parameter int ROM_BANK_W = 9,
  parameter int RAM_BANK_W = 4
) (
  input  logic CLK,
  input  logic GB_RST,
  gb_mbc_mapper_if.slave bus
);

  typedef enum logic {LAT_IDLE, LAT_ARMED} lat_st_e;

  logic                  wr_s1_q, wr_s2_q, wr_s3_q;
  logic [3:0]            a_s1_q, a_s2_q, a_cap_q;
  logic [7:0]            d_s1_q, d_s2_q, d_cap_q;

  logic [8:0]            rom_bank_q, rom_bank_d;
  logic [RAM_BANK_W-1:0] ram_bank_q, ram_bank_d;
  logic [1:0]            bank_hi_q, bank_hi_d;
  logic                  ram_en_q, ram_en_d;
  logic                  mbc1_mode_q, mbc1_mode_d;
  logic [3:0]            rtc_sel_q, rtc_sel_d;
  lat_st_e               lat_st_q, lat_st_d;

  logic [5:0]            sec_q, sec_d, min_q, min_d;
  logic [4:0]            hour_q, hour_d;
  logic [8:0]            day_q, day_d;
  logic                  halt_q, halt_d, carry_q, carry_d;
  logic [5:0]            lsec_q, lsec_d, lmin_q, lmin_d;
  logic [4:0]            lhour_q, lhour_d;
  logic [8:0]            lday_q, lday_d;
  logic                  lhalt_q, lhalt_d, lcarry_q, lcarry_d;

  logic                  commit, rtc_wr, latch_fire;
  logic                  is_ram_win, rtc_active;
  logic [8:0]            rom_hi_win, rom_lo_win;
  logic [7:0]            rtc_mux;

  always_ff @(posedge CLK) begin
    if (!GB_RST) begin
      wr_s1_q     <= 1'b1;
      wr_s2_q     <= 1'b1;
      wr_s3_q     <= 1'b1;
      a_s1_q      <= '0;
      a_s2_q      <= '0;
      a_cap_q     <= '0;
      d_s1_q      <= '0;
      d_s2_q      <= '0;
      d_cap_q     <= '0;
      rom_bank_q  <= 9'd1;
      ram_bank_q  <= '0;
      bank_hi_q   <= '0;
      ram_en_q    <= 1'b0;
      mbc1_mode_q <= 1'b0;
      rtc_sel_q   <= '0;
      lat_st_q    <= LAT_IDLE;
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      day_q       <= '0;
      halt_q      <= 1'b0;
      carry_q     <= 1'b0;
      lsec_q      <= '0;
      lmin_q      <= '0;
      lhour_q     <= '0;
      lday_q      <= '0;
      lhalt_q     <= 1'b0;
      lcarry_q    <= 1'b0;
    end else begin
      wr_s1_q     <= bus.GB_WR;
      wr_s2_q     <= wr_s1_q;
      wr_s3_q     <= wr_s2_q;
      a_s1_q      <= bus.GB_A;
      a_s2_q      <= a_s1_q;
      d_s1_q      <= bus.GB_D;
      d_s2_q      <= d_s1_q;
      // a/d are still stable in the cycles following the last synchronised-low WR sample
      if (!wr_s2_q) begin
        a_cap_q <= a_s2_q;
        d_cap_q <= d_s2_q;
      end
      rom_bank_q  <= rom_bank_d;
      ram_bank_q  <= ram_bank_d;
      bank_hi_q   <= bank_hi_d;
      ram_en_q    <= ram_en_d;
      mbc1_mode_q <= mbc1_mode_d;
      rtc_sel_q   <= rtc_sel_d;
      lat_st_q    <= lat_st_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      halt_q      <= halt_d;
      carry_q     <= carry_d;
      lsec_q      <= lsec_d;
      lmin_q      <= lmin_d;
      lhour_q     <= lhour_d;
      lday_q      <= lday_d;
      lhalt_q     <= lhalt_d;
      lcarry_q    <= lcarry_d;
    end
  end

  assign commit = wr_s2_q & ~wr_s3_q;

  always_comb begin
    rom_bank_d  = rom_bank_q;
    ram_bank_d  = ram_bank_q;
    bank_hi_d   = bank_hi_q;
    ram_en_d    = ram_en_q;
    mbc1_mode_d = mbc1_mode_q;
    rtc_sel_d   = rtc_sel_q;
    lat_st_d    = lat_st_q;
    rtc_wr      = 1'b0;
    latch_fire  = 1'b0;
    if (commit) begin
      case (a_cap_q)
        4'h0, 4'h1: ram_en_d = (d_cap_q[3:0] == 4'hA);
        4'h2, 4'h3: begin
          if (MODE == 5) begin
            if (a_cap_q == 4'h2) rom_bank_d[7:0] = d_cap_q;
            else                 rom_bank_d[8]   = d_cap_q[0];
          end else if (MODE == 1) begin
            rom_bank_d = {4'b0, (d_cap_q[4:0] == 5'd0) ? 5'd1 : d_cap_q[4:0]};
          end else begin
            rom_bank_d = {2'b0, (d_cap_q[6:0] == 7'd0) ? 7'd1 : d_cap_q[6:0]};
          end
        end
        4'h4, 4'h5: begin
          if (MODE == 5) begin
            ram_bank_d = d_cap_q[RAM_BANK_W-1:0];
          end else if (MODE == 1) begin
            bank_hi_d = d_cap_q[1:0];
          end else if (d_cap_q <= 8'h03) begin
            ram_bank_d = RAM_BANK_W'(d_cap_q[1:0]);
            rtc_sel_d  = 4'h0;
          end else if (d_cap_q >= 8'h08 && d_cap_q <= 8'h0C) begin
            rtc_sel_d = d_cap_q[3:0];
          end
        end
        4'h6, 4'h7: begin
          if (MODE == 1) begin
            mbc1_mode_d = d_cap_q[0];
          end else if (MODE == 3) begin
            if (lat_st_q == LAT_IDLE) begin
              if (d_cap_q == 8'h00) lat_st_d = LAT_ARMED;
            end else begin
              lat_st_d   = LAT_IDLE;
              latch_fire = (d_cap_q == 8'h01);
            end
          end
        end
        4'hA, 4'hB: rtc_wr = (MODE == 3) && ram_en_q && (rtc_sel_q != 4'h0);
        default: ;
      endcase
    end
  end

  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    halt_d  = halt_q;
    carry_d = carry_q;
    // a bus write to a live register takes priority and swallows a coincident tick
    if (rtc_wr) begin
      case (rtc_sel_q)
        4'h8: sec_d  = d_cap_q[5:0];
        4'h9: min_d  = d_cap_q[5:0];
        4'hA: hour_d = d_cap_q[4:0];
        4'hB: day_d[7:0] = d_cap_q;
        4'hC: begin
          day_d[8] = d_cap_q[0];
          halt_d   = d_cap_q[6];
          carry_d  = d_cap_q[7];
        end
        default: ;
      endcase
    end else if ((MODE == 3) && bus.RTC_TICK && !halt_q) begin
      if (sec_q != 6'd59) begin
        sec_d = sec_q + 6'd1;
      end else begin
        sec_d = '0;
        if (min_q != 6'd59) begin
          min_d = min_q + 6'd1;
        end else begin
          min_d = '0;
          if (hour_q != 5'd23) begin
            hour_d = hour_q + 5'd1;
          end else begin
            hour_d = '0;
            if (day_q != 9'd511) begin
              day_d = day_q + 9'd1;
            end else begin
              day_d   = '0;
              carry_d = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    lsec_d   = lsec_q;
    lmin_d   = lmin_q;
    lhour_d  = lhour_q;
    lday_d   = lday_q;
    lhalt_d  = lhalt_q;
    lcarry_d = lcarry_q;
    if (latch_fire) begin
      lsec_d   = sec_q;
      lmin_d   = min_q;
      lhour_d  = hour_q;
      lday_d   = day_q;
      lhalt_d  = halt_q;
      lcarry_d = carry_q;
    end
  end

  always_comb begin
    rtc_mux = 8'h00;
    case (rtc_sel_q)
      4'h8: rtc_mux = {2'b0, lsec_q};
      4'h9: rtc_mux = {2'b0, lmin_q};
      4'hA: rtc_mux = {3'b0, lhour_q};
      4'hB: rtc_mux = lday_q[7:0];
      4'hC: rtc_mux = {lcarry_q, lhalt_q, 5'b0, lday_q[8]};
      default: ;
    endcase
  end

  assign is_ram_win = (bus.GB_A == 4'hA) || (bus.GB_A == 4'hB);
  assign rtc_active = (MODE == 3) && (rtc_sel_q != 4'h0);

  assign rom_hi_win = (MODE == 1) ? {2'b0, bank_hi_q, rom_bank_q[4:0]} : rom_bank_q;
  assign rom_lo_win = ((MODE == 1) && mbc1_mode_q) ? {2'b0, bank_hi_q, 5'b0} : 9'd0;

  assign bus.ROM_A    = ROM_BANK_W'(bus.GB_A[2] ? rom_hi_win : rom_lo_win);
  assign bus.RAM_A    = (MODE == 1) ? (mbc1_mode_q ? RAM_BANK_W'(bank_hi_q) : '0) : ram_bank_q;
  assign bus.ROM_CS   = ~(!bus.GB_A[3] && GB_RST);
  assign bus.RAM_CS   = ~(is_ram_win && ram_en_q && !rtc_active && GB_RST);
  assign bus.RTC_OE   = is_ram_win && ram_en_q && rtc_active && !bus.GB_RD;
  assign bus.DDIR     = !bus.GB_RD && bus.GB_WR && (!bus.ROM_CS || !bus.RAM_CS || bus.RTC_OE);
  assign bus.RTC_DOUT = (MODE == 3) ? rtc_mux : 8'h00;

endmodule

// File: tb/tb_gb_mbc_mapper.sv
// Directed bench: one MBC5, one MBC1 and one MBC3 mapper share a single cartridge bus,
// each section resets all three and checks the instance of interest.
module tb_gb_mbc_mapper;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a   = 4'h0;
  logic [7:0] d   = 8'h00;
  logic       wr  = 1'b1;
  logic       rd  = 1'b1;
  logic       tick = 1'b0;
  int         n_vec  = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  gb_mbc_mapper_if #(.ROM_BANK_W(9), .RAM_BANK_W(4)) if5 ();
  gb_mbc_mapper_if #(.ROM_BANK_W(9), .RAM_BANK_W(4)) if1 ();
  gb_mbc_mapper_if #(.ROM_BANK_W(9), .RAM_BANK_W(4)) if3 ();

  assign if5.GB_A = a;  assign if5.GB_D = d;  assign if5.GB_WR = wr;
  assign if5.GB_RD = rd; assign if5.RTC_TICK = tick;
  assign if1.GB_A = a;  assign if1.GB_D = d;  assign if1.GB_WR = wr;
  assign if1.GB_RD = rd; assign if1.RTC_TICK = tick;
  assign if3.GB_A = a;  assign if3.GB_D = d;  assign if3.GB_WR = wr;
  assign if3.GB_RD = rd; assign if3.RTC_TICK = tick;

  gb_mbc_mapper #(.MODE(5), .ROM_BANK_W(9), .RAM_BANK_W(4)) u_mbc5 (.CLK(clk), .GB_RST(rst), .bus(if5.slave));
  gb_mbc_mapper #(.MODE(1), .ROM_BANK_W(9), .RAM_BANK_W(4)) u_mbc1 (.CLK(clk), .GB_RST(rst), .bus(if1.slave));
  gb_mbc_mapper #(.MODE(3), .ROM_BANK_W(9), .RAM_BANK_W(4)) u_mbc3 (.CLK(clk), .GB_RST(rst), .bus(if3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // WR low for 3 CLK then high; optional tick lands on the clock where the commit takes effect
  task automatic bus_wr(input logic [3:0] wa, input logic [7:0] wd, input bit tick_on_commit);
    rd = 1'b1; a = wa; d = wd; wr = 1'b0;
    cyc(3);
    wr = 1'b1;
    cyc(2);
    if (tick_on_commit) tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    rst = 1'b0; wr = 1'b1; rd = 1'b1; tick = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  task automatic tick_pulse();
    tick = 1'b1; cyc(1);
    tick = 1'b0; cyc(1);
  endtask

  task automatic rtc_latch();
    bus_wr(4'h6, 8'h00, 1'b0);
    bus_wr(4'h6, 8'h01, 1'b0);
  endtask

  task automatic rtc_set(input logic [7:0] sel, input logic [7:0] val);
    bus_wr(4'h4, sel, 1'b0);
    bus_wr(4'hA, val, 1'b0);
  endtask

  task automatic look(input logic [3:0] la, input logic lrd);
    a = la; rd = lrd; #1;
  endtask

  initial begin
    // MBC5 reset state and 9-bit ROM bank
    do_reset();
    look(4'h4, 1'b0);
    chk("m5_rst_rom_a", 32'(if5.ROM_A), 32'h1);
    chk("m5_rst_rom_cs", 32'(if5.ROM_CS), 32'h0);
    chk("m5_rst_ddir", 32'(if5.DDIR), 32'h1);
    look(4'hA, 1'b0);
    chk("m5_rst_ram_cs", 32'(if5.RAM_CS), 32'h1);
    chk("m5_rst_ddir_a", 32'(if5.DDIR), 32'h0);
    bus_wr(4'h2, 8'h00, 1'b0);
    look(4'h4, 1'b0);
    chk("m5_bank0_legal", 32'(if5.ROM_A), 32'h0);
    bus_wr(4'h3, 8'h01, 1'b0);
    look(4'h4, 1'b0);
    chk("m5_rom_a_100", 32'(if5.ROM_A), 32'h100);
    look(4'h1, 1'b0);
    chk("m5_lo_win", 32'(if5.ROM_A), 32'h0);

    // MBC5 RAM enable/bank, reset mid-write
    bus_wr(4'h0, 8'h0A, 1'b0);
    bus_wr(4'h4, 8'h05, 1'b0);
    look(4'hA, 1'b0);
    chk("m5_ram_cs_en", 32'(if5.RAM_CS), 32'h0);
    chk("m5_ram_a", 32'(if5.RAM_A), 32'h5);
    chk("m5_ram_ddir", 32'(if5.DDIR), 32'h1);
    look(4'hB, 1'b1);
    chk("m5_ram_cs_b", 32'(if5.RAM_CS), 32'h0);
    bus_wr(4'h0, 8'h00, 1'b0);
    look(4'hA, 1'b0);
    chk("m5_ram_cs_dis", 32'(if5.RAM_CS), 32'h1);
    rd = 1'b1; a = 4'h2; d = 8'h07; wr = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    wr = 1'b1;
    cyc(3);
    look(4'h4, 1'b0);
    chk("m5_rom_cs_in_rst", 32'(if5.ROM_CS), 32'h1);
    chk("m5_ddir_in_rst", 32'(if5.DDIR), 32'h0);
    rst = 1'b1;
    cyc(5);
    chk("m5_no_commit", 32'(if5.ROM_A), 32'h1);

    // MBC1 bank_lo zero rule and mode 1 windows
    do_reset();
    bus_wr(4'h2, 8'h05, 1'b0);
    look(4'h4, 1'b0);
    chk("m1_lo5", 32'(if1.ROM_A), 32'h5);
    bus_wr(4'h2, 8'h00, 1'b0);
    look(4'h4, 1'b0);
    chk("m1_zero_to_1", 32'(if1.ROM_A), 32'h1);
    bus_wr(4'h2, 8'h20, 1'b0);
    look(4'h4, 1'b0);
    chk("m1_5bit_test", 32'(if1.ROM_A), 32'h1);
    bus_wr(4'h4, 8'h02, 1'b0);
    look(4'h0, 1'b0);
    chk("m1_mode0_lo", 32'(if1.ROM_A), 32'h0);
    chk("m1_mode0_ram_a", 32'(if1.RAM_A), 32'h0);
    bus_wr(4'h6, 8'h01, 1'b0);
    look(4'h4, 1'b0);
    chk("m1_hi_41", 32'(if1.ROM_A), 32'h41);
    look(4'h0, 1'b0);
    chk("m1_lo_40", 32'(if1.ROM_A), 32'h40);
    chk("m1_ram_a", 32'(if1.RAM_A), 32'h2);

    // MBC3 RTC latch
    do_reset();
    bus_wr(4'h0, 8'h0A, 1'b0);
    rtc_set(8'h08, 8'd59);
    look(4'hA, 1'b0);
    chk("m3_dout_unlatched", 32'(if3.RTC_DOUT), 32'h0);
    tick_pulse();
    rtc_latch();
    chk("m3_sec_wrap", 32'(if3.RTC_DOUT), 32'h0);
    bus_wr(4'h4, 8'h09, 1'b0);
    rtc_latch();
    chk("m3_min_carry", 32'(if3.RTC_DOUT), 32'h1);
    rtc_set(8'h08, 8'd30);
    bus_wr(4'h6, 8'h00, 1'b0);
    bus_wr(4'h6, 8'h02, 1'b0);
    bus_wr(4'h6, 8'h01, 1'b0);
    chk("m3_no_latch", 32'(if3.RTC_DOUT), 32'h0);
    rtc_latch();
    chk("m3_relatch", 32'(if3.RTC_DOUT), 32'd30);

    // MBC3 day overflow carry and halt
    rtc_set(8'h0C, 8'h01);
    rtc_set(8'h0B, 8'hFF);
    rtc_set(8'h0A, 8'd23);
    rtc_set(8'h09, 8'd59);
    rtc_set(8'h08, 8'd59);
    tick_pulse();
    rtc_latch();
    bus_wr(4'h4, 8'h0C, 1'b0);
    chk("m3_dh_carry", 32'(if3.RTC_DOUT), 32'h80);
    bus_wr(4'h4, 8'h0B, 1'b0);
    chk("m3_dl_zero", 32'(if3.RTC_DOUT), 32'h0);
    bus_wr(4'h4, 8'h0A, 1'b0);
    chk("m3_hour_zero", 32'(if3.RTC_DOUT), 32'h0);
    rtc_set(8'h08, 8'd5);
    rtc_set(8'h0C, 8'h40);
    tick_pulse();
    tick_pulse();
    tick_pulse();
    rtc_latch();
    bus_wr(4'h4, 8'h08, 1'b0);
    chk("m3_halt_frozen", 32'(if3.RTC_DOUT), 32'd5);
    bus_wr(4'h4, 8'h0C, 1'b0);
    chk("m3_dh_halt", 32'(if3.RTC_DOUT), 32'h40);

    // write beats coincident tick; RTC read enables
    rtc_set(8'h0C, 8'h00);
    bus_wr(4'h4, 8'h08, 1'b0);
    bus_wr(4'hA, 8'd10, 1'b1);
    rtc_latch();
    chk("m3_write_wins", 32'(if3.RTC_DOUT), 32'd10);
    tick_pulse();
    rtc_latch();
    chk("m3_tick_runs", 32'(if3.RTC_DOUT), 32'd11);
    look(4'hA, 1'b0);
    chk("m3_rtc_oe", 32'(if3.RTC_OE), 32'h1);
    chk("m3_rtc_ddir", 32'(if3.DDIR), 32'h1);
    chk("m3_rtc_ram_cs", 32'(if3.RAM_CS), 32'h1);
    chk("m5_rtc_oe_tied", 32'(if5.RTC_OE), 32'h0);
    chk("m5_rtc_dout_tied", 32'(if5.RTC_DOUT), 32'h0);
    chk("m5_ram_cs_shared", 32'(if5.RAM_CS), 32'h0);
    look(4'hA, 1'b1);
    chk("m3_rtc_oe_rd_hi", 32'(if3.RTC_OE), 32'h0);
    chk("m3_ddir_rd_hi", 32'(if3.DDIR), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/gb_mbc_mapper.md
Name: gb_mbc_mapper

Overview:
- Clocked, parametrised Game Boy cartridge memory-bank controller; successor to the asynchronous MBC5-only bank decoder.
- Samples the cartridge bus with a local oscillator clock and commits bank-register writes on the synchronised WR rising edge.
- MODE parameter selects MBC1, MBC3 or MBC5 register maps. MBC3 adds a real-time clock with latch.
- Drives ROM/SRAM upper address lines, chip selects, data-buffer direction, and RTC read data.

Parameters:
MODE, 5, register map: 1 = MBC1, 3 = MBC3 (with RTC), 5 = MBC5
ROM_BANK_W, 9, ROM bank register width (MBC1/MBC3 use low 7 bits, upper bits driven 0)
RAM_BANK_W, 4, SRAM bank register width (MBC1/MBC3 use low 2 bits)

Ports:
CLK  input  1  local oscillator clock, >=16 MHz
GB_RST  input  1  synchronous active-low reset, sampled on CLK rising edge
GB_A  input  4  cartridge address bits [15:12]
GB_D  input  8  cartridge data bus
GB_WR  input  1  write strobe, active-low
GB_RD  input  1  read strobe, active-low
RTC_TICK  input  1  one-CLK pulse per second
ROM_A  output  ROM_BANK_W  ROM address [ROM_BANK_W+13:14]
RAM_A  output  RAM_BANK_W  SRAM address [RAM_BANK_W+12:13]
ROM_CS  output  1  ROM select, active-low
RAM_CS  output  1  SRAM select, active-low
DDIR  output  1  data buffer direction; 1 = cartridge drives the bus
RTC_OE  output  1  RTC data enable onto the bus
RTC_DOUT  output  8  latched RTC register value

Behaviour:
- Reset (GB_RST = 0 at a CLK edge) sets:
  - rom_bank = 1, ram_bank = 0, ram_en = 0, mbc1_mode = 0, rtc_sel = none.
  - All RTC counters, halt and carry = 0.
  - Latch FSM = IDLE; latched RTC copy = 0.
- Reset mid-write: the pending commit is discarded.
- Synchroniser: GB_WR, GB_A and GB_D pass through two flops each.
- Capture: while the synchronised WR is 0, a_cap and d_cap load every cycle.
- Commit: fires when the synchronised WR goes 0->1, using a_cap/d_cap. Register updates 1 CLK later, i.e. at most 4 CLK after the GB_WR rising edge. Exactly one commit per WR pulse.
- Combinational outputs:
  - ROM_CS = 0 iff GB_A < 8 and GB_RST = 1.
  - RAM_CS = 0 iff GB_A is 0xA or 0xB, ram_en = 1, no RTC register selected, and GB_RST = 1.
  - RTC_OE = 1 iff GB_A is 0xA or 0xB, ram_en = 1, RTC selected, and GB_RD = 0.
  - DDIR = 1 iff GB_RD = 0, GB_WR = 1, and (ROM_CS = 0, RAM_CS = 0 or RTC_OE = 1).
- ROM_A: bank for 0x4000-0x7FFF = effective bank; bank for 0x0000-0x3FFF = 0 (MBC1 mode 1: {bank_hi, 5'b0}).
- Commit decode, all modes: 0x0/0x1 sets ram_en = (d_cap[3:0] == 4'hA).
- MODE 5:
  - 0x2: rom_bank[7:0] = d.
  - 0x3: rom_bank[8] = d[0].
  - 0x4/0x5: ram_bank = d[RAM_BANK_W-1:0].
  - Bank 0 is legal in the upper window.
- MODE 1:
  - 0x2/0x3: bank_lo = d[4:0]; a value of 0 becomes 1, tested on 5 bits only.
  - 0x4/0x5: bank_hi = d[1:0].
  - 0x6/0x7: mbc1_mode = d[0].
  - Effective ROM bank = {bank_hi, bank_lo}; RAM bank = mbc1_mode ? bank_hi : 0.
- MODE 3:
  - 0x2/0x3: rom_bank = d[6:0], 0 becomes 1.
  - 0x4/0x5: d 0x00-0x03 sets ram_bank and clears rtc_sel; d 0x08-0x0C sets rtc_sel = d (S, M, H, DL, DH); other values are ignored.
  - 0x6/0x7 latch FSM: IDLE --d=0x00--> ARMED --d=0x01--> copy live counters to the latched copy, return to IDLE. Any other value in ARMED returns to IDLE.
  - 0xA/0xB with ram_en and RTC selected: write d into the selected live register.
  - RTC_DOUT = latched copy of the selected register.
  - DH register: bit0 = day[8], bit6 = halt, bit7 = carry; unused bits read 0.
- RTC (MODE 3 only; otherwise RTC_OE and RTC_DOUT are tied to 0):
  - On RTC_TICK with halt = 0: sec increments 0..59 and wraps, carrying into min 0..59, then hour 0..23, then day 0..511.
  - Day wrap 511->0 sets carry; carry is sticky until cleared by a DH write.
  - Tick and live-register write in the same CLK: the write wins and that tick is dropped.
  - halt = 1: counters frozen, ticks ignored.
- Writes to 0x8-0x9 and 0xC-0xF are ignored.

Test Plan:
1. MODE 5 after reset: A = 0x4, RD low → ROM_A = 1, ROM_CS = 0. Write 0x2 = 0x00, then 0x3 = 0x01 → ROM_A = 0x100 within 4 CLK of WR high; A = 0x1 → ROM_A = 0.
2. MODE 5 RAM enable: write 0x0 = 0x0A, then 0x4 = 0x05 → A = 0xA gives RAM_CS = 0, RAM_A = 5. Write 0x0 = 0x00 → RAM_CS = 1. Reset asserted mid-WR-pulse → no commit, ROM_A = 1.
3. MODE 1: write 0x2 = 0x00 → bank_lo = 1. Write 0x2 = 0x20 → bank_lo = 1 (5-bit test). Write 0x4 = 0x02, 0x6 = 0x01 → A = 0x4 gives ROM_A = 0x41, A = 0x0 gives ROM_A = 0x40, RAM_A = 2.
4. MODE 3 latch: enable RAM, select 0x08, write A = 0xA data 59, pulse RTC_TICK → live sec = 0, min = 1. RTC_DOUT stays 0 until writes 0x6 = 0x00 then 0x6 = 0x01; then RTC_DOUT = 0. Select 0x09, latch → RTC_DOUT = 1. Sequence 0x00, 0x02, 0x01 → no latch.
5. MODE 3 day carry: DH = 0x01, DL = 0xFF, H = 23, M = 59, S = 59, one tick → after latch, DH reads 0x80 and DL reads 0x00. Write DH = 0x40 → subsequent ticks leave S unchanged.
6. Tick coincident with an S write of 10 → S = 10, not 11. RD low with RTC selected → RTC_OE = 1, DDIR = 1, RAM_CS = 1.
